// File: rtl/accum_reg.sv
// accum_reg -- parametrised shift-and-accumulate register for the sequential
// multiplier datapath. Keeps the hold/clear/load behaviour of the old
// product register and adds an in-place shifted accumulate, a logical left
// shift, a sticky overflow flag and a saturating accumulate counter whose
// terminal step produces a one-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock
//   aclr_n     asynchronous active-low reset, clears every output
//   sclr_n     synchronous active-low clear, qualified by clk_ena
//   clk_ena    clock enable; 0 holds all state (done still self-clears)
//   mode       00 hold, 01 load, 10 accumulate, 11 shift
//   shift_amt  left-shift amount for datain (load/acc) or reg_out (shift)
//   datain     unsigned operand
//   reg_out    register contents
//   ovf        sticky overflow / lost-bit flag
//   acc_cnt    accumulates since last load/clear, saturates at ACC_N
//   done       one-cycle pulse when acc_cnt reaches ACC_N
module accum_reg #(
   parameter int WIDTH    = 16,
   parameter int IN_WIDTH = 8,
   parameter int ACC_N    = 8,
   localparam int SW      = $clog2(WIDTH),
   localparam int CW      = $clog2(ACC_N + 1)
) (
   input  logic                clk,
   input  logic                aclr_n,
   input  logic                sclr_n,
   input  logic                clk_ena,
   input  logic [1:0]          mode,
   input  logic [SW-1:0]       shift_amt,
   input  logic [IN_WIDTH-1:0] datain,
   output logic [WIDTH-1:0]    reg_out,
   output logic                ovf,
   output logic [CW-1:0]       acc_cnt,
   output logic                done
);

   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_LOAD  = 2'b01;
   localparam logic [1:0] M_ACC   = 2'b10;
   localparam logic [1:0] M_SHIFT = 2'b11;

   localparam logic [CW-1:0] CNT_MAX  = CW'(ACC_N);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACC_N - 1);

   // Shifts are done at double width so that every bit pushed past the top
   // of the register is still visible for the overflow flag.
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] reg_shl;
   logic               lost;
   logic               shl_lost;
   logic [WIDTH:0]     sum;
   logic [CW-1:0]      cnt_inc;

   always_comb begin
      addend   = {{(2*WIDTH-IN_WIDTH){1'b0}}, datain} << shift_amt;
      lost     = |addend[2*WIDTH-1:WIDTH];
      reg_shl  = {{WIDTH{1'b0}}, reg_out} << shift_amt;
      shl_lost = |reg_shl[2*WIDTH-1:WIDTH];
      sum      = {1'b0, reg_out} + {1'b0, addend[WIDTH-1:0]};
      cnt_inc  = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         reg_out <= '0;
         ovf     <= 1'b0;
         acc_cnt <= '0;
         done    <= 1'b0;
      end else begin
         // done is a fixed one-clock pulse: it drops on the next edge even
         // when the enable is low.
         done <= 1'b0;
         if (clk_ena) begin
            if (!sclr_n) begin
               reg_out <= '0;
               ovf     <= 1'b0;
               acc_cnt <= '0;
            end else begin
               unique case (mode)
                  M_HOLD: ;
                  M_LOAD: begin
                     reg_out <= addend[WIDTH-1:0];
                     ovf     <= lost;
                     acc_cnt <= '0;
                  end
                  M_ACC: begin
                     reg_out <= sum[WIDTH-1:0];
                     ovf     <= ovf | sum[WIDTH] | lost;
                     acc_cnt <= cnt_inc;
                     // Only the ACC_N-1 -> ACC_N step fires; saturated
                     // accumulates leave the count at ACC_N and stay quiet.
                     done    <= (acc_cnt == CNT_LAST);
                  end
                  M_SHIFT: begin
                     reg_out <= reg_shl[WIDTH-1:0];
                     ovf     <= ovf | shl_lost;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_accum_reg.sv
// tb_accum_reg -- directed-vector bench for accum_reg at default parameters
// (WIDTH=16, IN_WIDTH=8, ACC_N=8). Expected values are hand-computed.
module tb_accum_reg;

   logic        clk = 1'b0;
   logic        aclr_n;
   logic        sclr_n;
   logic        clk_ena;
   logic [1:0]  mode;
   logic [3:0]  shift_amt;
   logic [7:0]  datain;
   logic [15:0] reg_out;
   logic        ovf;
   logic [3:0]  acc_cnt;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   accum_reg #(.WIDTH(16), .IN_WIDTH(8), .ACC_N(8)) dut (
      .clk      (clk),
      .aclr_n   (aclr_n),
      .sclr_n   (sclr_n),
      .clk_ena  (clk_ena),
      .mode     (mode),
      .shift_amt(shift_amt),
      .datain   (datain),
      .reg_out  (reg_out),
      .ovf      (ovf),
      .acc_cnt  (acc_cnt),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] r, input logic o,
                          input logic [3:0] c, input logic d);
      chk({tag, ".reg"},  32'(reg_out), 32'(r));
      chk({tag, ".ovf"},  32'(ovf),     32'(o));
      chk({tag, ".cnt"},  32'(acc_cnt), 32'(c));
      chk({tag, ".done"}, 32'(done),    32'(d));
   endtask

   // Apply one command and advance to just after the next rising edge.
   task automatic op(input logic [1:0] m, input logic [3:0] sa, input logic [7:0] d);
      mode = m; shift_amt = sa; datain = d;
      @(posedge clk); #1;
   endtask

   logic [7:0] mult = 8'h53;

   function automatic logic [7:0] mul_in(input int i);
      return mult[i] ? 8'hAC : 8'h00;
   endfunction

   // Load 0 then run the 8 shift-add steps of 0xAC * 0x53.
   task automatic mul_run(input string tag);
      op(2'b01, 4'd0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         op(2'b10, 4'(i), mul_in(i));
         if (i == 6) chk({tag, ".pre_done"}, 32'(done), 32'd0);
      end
      chk_all({tag, ".final"}, 16'h37C4, 1'b0, 4'd8, 1'b1);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      aclr_n = 1'b0; sclr_n = 1'b1; clk_ena = 1'b1;
      mode = 2'b00; shift_amt = 4'd0; datain = 8'h00;
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset", 16'h0, 1'b0, 4'd0, 1'b0);
      aclr_n = 1'b1;

      // Multiply, then a saturated 9th accumulate must not re-fire done.
      mul_run("mul");
      op(2'b10, 4'd0, 8'h00);
      chk_all("mul.9th", 16'h37C4, 1'b0, 4'd8, 1'b0);
      // Load during saturation re-arms the counter.
      op(2'b01, 4'd0, 8'h05);
      chk_all("mul.reload", 16'h0005, 1'b0, 4'd0, 1'b0);

      // Overflow: 0xFF00 + 0xFF00 carries out.
      op(2'b01, 4'd8, 8'hFF);
      chk_all("ovf.load", 16'hFF00, 1'b0, 4'd0, 1'b0);
      op(2'b10, 4'd8, 8'hFF);
      chk_all("ovf.acc", 16'hFE00, 1'b1, 4'd1, 1'b0);
      for (int i = 0; i < 5; i++) op(2'b00, 4'd0, 8'h00);
      chk_all("ovf.hold", 16'hFE00, 1'b1, 4'd1, 1'b0);
      op(2'b01, 4'd0, 8'h01);
      chk_all("ovf.reload", 16'h0001, 1'b0, 4'd0, 1'b0);
      // Load whose shifted operand spills off the top sets ovf.
      op(2'b01, 4'd12, 8'h31);
      chk_all("ovf.loadlost", 16'h1000, 1'b1, 4'd0, 1'b0);

      // Shift.
      op(2'b01, 4'd8, 8'h81);
      chk_all("shl.load", 16'h8100, 1'b0, 4'd0, 1'b0);
      op(2'b11, 4'd1, 8'h00);
      chk_all("shl.1", 16'h0200, 1'b1, 4'd0, 1'b0);
      op(2'b01, 4'd0, 8'h03);
      op(2'b11, 4'd4, 8'hFF);
      chk_all("shl.4", 16'h0030, 1'b0, 4'd0, 1'b0);

      // Enable gating and synchronous clear.
      op(2'b01, 4'd8, 8'h12);
      op(2'b10, 4'd0, 8'h34);
      chk_all("ena.setup", 16'h1234, 1'b0, 4'd1, 1'b0);
      clk_ena = 1'b0; sclr_n = 1'b0;
      for (int i = 0; i < 3; i++) op(2'b10, 4'd0, 8'h11);
      chk_all("ena.off", 16'h1234, 1'b0, 4'd1, 1'b0);
      clk_ena = 1'b1;
      op(2'b10, 4'd0, 8'h11);
      chk_all("sclr", 16'h0000, 1'b0, 4'd0, 1'b0);
      sclr_n = 1'b1;

      // Async reset mid-way through the 5th accumulate.
      op(2'b01, 4'd0, 8'h00);
      for (int i = 0; i < 4; i++) op(2'b10, 4'(i), mul_in(i));
      chk("arst.pre.cnt", 32'(acc_cnt), 32'd4);
      mode = 2'b10; shift_amt = 4'd4; datain = mul_in(4);
      #2 aclr_n = 1'b0;
      #1 chk_all("arst.now", 16'h0, 1'b0, 4'd0, 1'b0);
      @(posedge clk); #1;
      chk_all("arst.held", 16'h0, 1'b0, 4'd0, 1'b0);
      aclr_n = 1'b1;
      mul_run("rerun");
      // done drops on the next edge even with the enable low.
      clk_ena = 1'b0;
      op(2'b10, 4'd0, 8'hAC);
      chk_all("done.ena0", 16'h37C4, 1'b0, 4'd8, 1'b0);
      clk_ena = 1'b1;

      // Clear on the edge the 8th accumulate would happen.
      op(2'b01, 4'd0, 8'h00);
      for (int i = 0; i < 7; i++) op(2'b10, 4'(i), mul_in(i));
      chk("cvd.cnt7", 32'(acc_cnt), 32'd7);
      sclr_n = 1'b0;
      op(2'b10, 4'd7, mul_in(7));
      chk_all("cvd.clr", 16'h0, 1'b0, 4'd0, 1'b0);
      sclr_n = 1'b1;
      op(2'b00, 4'd0, 8'h00);
      chk_all("cvd.after", 16'h0, 1'b0, 4'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
